// File: rtl/mdio_pkg.sv
// Purpose: shared types and constants for the Clause 22 MDIO PHY-side responder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mdio_pkg;

    // Frame-decoder states; bit fields arrive MSB first on MDC rising edges.
    typedef enum logic [2:0] {
        PRE,
        ST2,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA
    } mdio_state_e;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam logic [4:0] BMCR   = 5'd0;
    localparam logic [4:0] BMSR   = 5'd1;
    localparam logic [4:0] PHYID1 = 5'd2;
    localparam logic [4:0] PHYID2 = 5'd3;

    localparam int PRE_LEN = 32;

    // Status and ID registers cannot be changed by the master.
    function automatic logic is_read_only(input logic [4:0] idx);
        return (idx == BMSR) || (idx == PHYID1) || (idx == PHYID2);
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Purpose: bring MDC/MDIO into the Eth_Clk domain and flag MDC edges.
// Latency: 2 cycles to the synchronized level, edge pulse in the cycle the new level appears.
// Backpressure: none; MDIO has no flow control.
//
// Ports: clk/rst (sync, active-high); mdc_in/mdio_in raw pins;
//        mdc_rise/mdc_fall one-cycle edge pulses; mdio_sync aligned with the edge pulses.
module mdio_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic mdc_in,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_sync
);

    logic [1:0] mdc_sync_q,  mdc_sync_d;
    logic [1:0] mdio_sync_q, mdio_sync_d;
    logic       mdc_dly_q,   mdc_dly_d;

    always_comb begin
        mdc_sync_d  = {mdc_sync_q[0], mdc_in};
        mdio_sync_d = {mdio_sync_q[0], mdio_in};
        mdc_dly_d   = mdc_sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_sync_q  <= 2'b00;
            mdio_sync_q <= 2'b11;   // MDIO idles high via pull-up
            mdc_dly_q   <= 1'b0;
        end else begin
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            mdc_dly_q   <= mdc_dly_d;
        end
    end

    // Both lines go through the same two stages, so mdio_sync is the value
    // that was on the wire when MDC moved.
    assign mdc_rise  =  mdc_sync_q[1] & ~mdc_dly_q;
    assign mdc_fall  = ~mdc_sync_q[1] &  mdc_dly_q;
    assign mdio_sync =  mdio_sync_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Purpose: Clause 22 MDIO PHY-side slave serving a 32x16 register file.
// Latency: read data driven on MDC falls; write commit 1 Eth_Clk after the last data-bit rise.
// Backpressure: none; the master owns MDC and the slave follows it.
//
// Ports: Eth_Clk/Eth_Rst (sync, active-high); MDC_In, MDIO_I from the pins;
//        MDIO_O/MDIO_OE to the IOBUF; Wr_Strb/Wr_Addr/Wr_Data committed-write report;
//        Frame_Err pulse on a bad ST, OP or TA field.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0007,
    parameter logic [15:0] PHY_ID2  = 16'hC0F1,
    parameter logic [15:0] BMCR_RST = 16'h3100,
    parameter logic [15:0] BMSR_RST = 16'h786D
) (
    input  logic        Eth_Clk,
    input  logic        Eth_Rst,
    input  logic        MDC_In,
    input  logic        MDIO_I,
    output logic        MDIO_O,
    output logic        MDIO_OE,
    output logic        Wr_Strb,
    output logic [4:0]  Wr_Addr,
    output logic [15:0] Wr_Data,
    output logic        Frame_Err
);

    localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

    logic mdc_rise, mdc_fall, mdio_s;

    mdio_edge_sync u_sync (
        .clk       (Eth_Clk),
        .rst       (Eth_Rst),
        .mdc_in    (MDC_In),
        .mdio_in   (MDIO_I),
        .mdc_rise  (mdc_rise),
        .mdc_fall  (mdc_fall),
        .mdio_sync (mdio_s)
    );

    mdio_state_e state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        op_hi_q, op_hi_d;       // first opcode bit
    logic        is_rd_q, is_rd_d;
    logic [8:0]  hdr_q, hdr_d;           // PHYAD then REGAD bits, shifted in
    logic [4:0]  regad_q, regad_d;
    logic        match_q, match_d;
    logic [15:0] shreg_q, shreg_d;       // read data out / write data in
    logic        rd_drv_q, rd_drv_d;     // we own the line for this read
    logic        mdio_oe_q, mdio_oe_d;
    logic        mdio_o_q, mdio_o_d;
    logic        wr_strb_q, wr_strb_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic        soft_rst_q, soft_rst_d;

    logic [15:0] regs_q [32];
    logic [15:0] regs_d [32];

    logic [4:0]  rd_idx;
    logic [15:0] rd_word;
    logic [15:0] wr_word;

    function automatic logic [15:0] rst_val(input int i);
        logic [4:0] idx;
        idx = 5'(i);
        if (idx == BMCR)        return BMCR_RST;
        else if (idx == BMSR)   return BMSR_RST;
        else if (idx == PHYID1) return PHY_ID1;
        else if (idx == PHYID2) return PHY_ID2;
        else                    return 16'h0000;
    endfunction

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        op_hi_d     = op_hi_q;
        is_rd_d     = is_rd_q;
        hdr_d       = hdr_q;
        regad_d     = regad_q;
        match_d     = match_q;
        shreg_d     = shreg_q;
        rd_drv_d    = rd_drv_q;
        mdio_oe_d   = mdio_oe_q;
        mdio_o_d    = mdio_o_q;
        wr_strb_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        soft_rst_d  = 1'b0;
        for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];

        // Register being addressed once the last REGAD bit is on the wire.
        rd_idx  = {hdr_q[3:0], mdio_s};
        rd_word = regs_q[rd_idx];
        if (rd_idx == BMCR) rd_word[15] = 1'b0;   // soft-reset bit self-clears
        wr_word = {shreg_q[14:0], mdio_s};

        if (mdc_rise) begin
            case (state_q)
                PRE: begin
                    if (mdio_s) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q == PRE_MAX) begin
                        // This 0 is the first ST bit.
                        state_d   = ST2;
                        pre_cnt_d = 6'd0;
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end
                ST2: begin
                    if (mdio_s) begin
                        state_d   = OP;
                        bit_cnt_d = 4'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = PRE;
                    end
                end
                OP: begin
                    op_hi_d = mdio_s;
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else if ({op_hi_q, mdio_s} == OP_RD) begin
                        is_rd_d   = 1'b1;
                        state_d   = PHYAD;
                        bit_cnt_d = 4'd4;
                    end else if ({op_hi_q, mdio_s} == OP_WR) begin
                        is_rd_d   = 1'b0;
                        state_d   = PHYAD;
                        bit_cnt_d = 4'd4;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = PRE;
                    end
                end
                PHYAD: begin
                    hdr_d = {hdr_q[7:0], mdio_s};
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else begin
                        state_d   = REGAD;
                        bit_cnt_d = 4'd4;
                    end
                end
                REGAD: begin
                    hdr_d = {hdr_q[7:0], mdio_s};
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else begin
                        regad_d   = rd_idx;
                        match_d   = (hdr_q[8:4] == PHY_ADDR);
                        shreg_d   = rd_word;
                        state_d   = TA;
                        bit_cnt_d = 4'd1;
                    end
                end
                TA: begin
                    if (bit_cnt_q != 4'd0) begin
                        // First TA bit is Z on a read; take the line from the next fall.
                        if (is_rd_q && match_q) rd_drv_d = 1'b1;
                        if (!is_rd_q && !mdio_s) begin
                            frame_err_d = 1'b1;
                            state_d     = PRE;
                        end else begin
                            bit_cnt_d = 4'd0;
                        end
                    end else if (!is_rd_q && mdio_s) begin
                        frame_err_d = 1'b1;
                        state_d     = PRE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd15;
                    end
                end
                DATA: begin
                    if (!is_rd_q) shreg_d = wr_word;
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else begin
                        state_d   = PRE;
                        pre_cnt_d = 6'd0;
                        if (!is_rd_q && match_q && !is_read_only(regad_q)) begin
                            wr_strb_d = 1'b1;
                            wr_addr_d = regad_q;
                            wr_data_d = wr_word;
                            if (regad_q == BMCR && wr_word[15])
                                soft_rst_d = 1'b1;
                            else
                                regs_d[regad_q] = wr_word;
                        end
                    end
                end
                default: state_d = PRE;
            endcase
        end else if (mdc_fall && rd_drv_q) begin
            // Drive only on falls so the master's rising-edge sample sees settled data.
            case (state_q)
                TA: begin
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = 1'b0;
                end
                DATA: begin
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = shreg_q[15];
                    shreg_d   = {shreg_q[14:0], 1'b0};
                end
                default: begin
                    // Fall after data bit 0: hand the line back.
                    mdio_oe_d = 1'b0;
                    mdio_o_d  = 1'b1;
                    rd_drv_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Eth_Clk) begin
        if (Eth_Rst) begin
            state_q     <= PRE;
            pre_cnt_q   <= 6'd0;
            bit_cnt_q   <= 4'd0;
            op_hi_q     <= 1'b0;
            is_rd_q     <= 1'b0;
            hdr_q       <= 9'd0;
            regad_q     <= 5'd0;
            match_q     <= 1'b0;
            shreg_q     <= 16'd0;
            rd_drv_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
            mdio_o_q    <= 1'b1;
            wr_strb_q   <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 16'd0;
            frame_err_q <= 1'b0;
            soft_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            op_hi_q     <= op_hi_d;
            is_rd_q     <= is_rd_d;
            hdr_q       <= hdr_d;
            regad_q     <= regad_d;
            match_q     <= match_d;
            shreg_q     <= shreg_d;
            rd_drv_q    <= rd_drv_d;
            mdio_oe_q   <= mdio_oe_d;
            mdio_o_q    <= mdio_o_d;
            wr_strb_q   <= wr_strb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            soft_rst_q  <= soft_rst_d;
        end
    end

    // Register file: hard reset and BMCR soft reset both reload PHY defaults.
    always_ff @(posedge Eth_Clk) begin
        for (int i = 0; i < 32; i++) begin
            if (Eth_Rst || soft_rst_q) regs_q[i] <= rst_val(i);
            else                       regs_q[i] <= regs_d[i];
        end
    end

    assign MDIO_O    = mdio_o_q;
    assign MDIO_OE   = mdio_oe_q;
    assign Wr_Strb   = wr_strb_q;
    assign Wr_Addr   = wr_addr_q;
    assign Wr_Data   = wr_data_q;
    assign Frame_Err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Purpose: directed self-checking bench for mdio_phy_responder acting as an MDIO master.
// Latency: MDC half-period of 8 Eth_Clk cycles.
// Backpressure: none.
module tb_mdio_phy_responder;

    logic        Eth_Clk = 1'b0;
    logic        Eth_Rst = 1'b1;
    logic        mdc     = 1'b0;
    logic        m_oe    = 1'b1;
    logic        m_val   = 1'b1;
    logic        mdio_line;
    logic        MDIO_O, MDIO_OE, Wr_Strb, Frame_Err;
    logic [4:0]  Wr_Addr;
    logic [15:0] Wr_Data;

    int nvec = 0;
    int nbad = 0;

    // Open-drain style bus with a pull-up when nobody drives.
    assign mdio_line = MDIO_OE ? MDIO_O : (m_oe ? m_val : 1'b1);

    always #10 Eth_Clk = ~Eth_Clk;

    mdio_phy_responder dut (
        .Eth_Clk   (Eth_Clk),
        .Eth_Rst   (Eth_Rst),
        .MDC_In    (mdc),
        .MDIO_I    (mdio_line),
        .MDIO_O    (MDIO_O),
        .MDIO_OE   (MDIO_OE),
        .Wr_Strb   (Wr_Strb),
        .Wr_Addr   (Wr_Addr),
        .Wr_Data   (Wr_Data),
        .Frame_Err (Frame_Err)
    );

    // Cumulative activity counters; frames take differences.
    int          strb_tot = 0;
    int          err_tot  = 0;
    int          oe_tot   = 0;
    logic [4:0]  last_addr = 5'd0;
    logic [15:0] last_data = 16'd0;

    always @(negedge Eth_Clk) begin
        if (Wr_Strb) begin
            strb_tot  <= strb_tot + 1;
            last_addr <= Wr_Addr;
            last_data <= Wr_Data;
        end
        if (Frame_Err) err_tot <= err_tot + 1;
        if (MDIO_OE)   oe_tot  <= oe_tot + 1;
    end

    // Per-frame results.
    logic [15:0] rd_dat;
    logic [1:0]  ta_oe;
    logic        ta2_line;
    logic        data_oe_all;
    logic        oe_after;
    int          strb_cnt, err_cnt, oe_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mbit(input logic drv, input logic val, output logic smp, output logic oe_s);
        @(negedge Eth_Clk);
        mdc   = 1'b0;
        m_oe  = drv;
        m_val = val;
        repeat (8) @(negedge Eth_Clk);
        smp  = mdio_line;
        oe_s = MDIO_OE;
        mdc  = 1'b1;
        repeat (7) @(negedge Eth_Clk);
    endtask

    // One master transaction; ndata < 16 stops with MDC high after that many data bits.
    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                         input int ndata);
        logic s, o, rd;
        int   sb, eb, ob;
        rd = (op == 2'b10);
        sb = strb_tot; eb = err_tot; ob = oe_tot;
        rd_dat = 16'h0000;
        for (int i = 0; i < npre; i++) mbit(1'b1, 1'b1, s, o);
        mbit(1'b1, 1'b0, s, o);
        mbit(1'b1, 1'b1, s, o);
        for (int i = 1; i >= 0; i--) mbit(1'b1, op[i], s, o);
        for (int i = 4; i >= 0; i--) mbit(1'b1, pa[i], s, o);
        for (int i = 4; i >= 0; i--) mbit(1'b1, ra[i], s, o);
        mbit(!rd, ta[1], s, o); ta_oe[1] = o;
        mbit(!rd, ta[0], s, o); ta_oe[0] = o; ta2_line = s;
        data_oe_all = 1'b1;
        for (int i = 15; i > 15 - ndata; i--) begin
            mbit(!rd, wd[i], s, o);
            rd_dat[i]   = s;
            data_oe_all = data_oe_all & o;
        end
        if (ndata == 16) begin
            @(negedge Eth_Clk);
            mdc  = 1'b0;
            m_oe = 1'b1;
            m_val = 1'b1;
            repeat (8) @(negedge Eth_Clk);
            oe_after = MDIO_OE;
        end
        @(negedge Eth_Clk);
        strb_cnt = strb_tot - sb;
        err_cnt  = err_tot - eb;
        oe_cnt   = oe_tot - ob;
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] ra, input logic [15:0] exp);
        frame(32, 2'b10, 5'd1, ra, 2'b11, 16'h0000, 16);
        chk(tag, {16'h0, rd_dat}, {16'h0, exp});
    endtask

    initial begin
        repeat (5) @(negedge Eth_Clk);
        Eth_Rst = 1'b0;
        @(negedge Eth_Clk);
        chk("rst_oe",    {31'h0, MDIO_OE},   32'h0);
        chk("rst_o",     {31'h0, MDIO_O},    32'h1);
        chk("rst_strb",  {31'h0, Wr_Strb},   32'h0);
        chk("rst_addr",  {27'h0, Wr_Addr},   32'h0);
        chk("rst_data",  {16'h0, Wr_Data},   32'h0);
        chk("rst_err",   {31'h0, Frame_Err}, 32'h0);

        // Read reg2: line taken on TA bit 2 driving 0, then PHY_ID1, released afterwards.
        frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0000, 16);
        chk("rd2_ta_oe",  {30'h0, ta_oe},       32'h1);
        chk("rd2_ta_bit", {31'h0, ta2_line},    32'h0);
        chk("rd2_data",   {16'h0, rd_dat},      32'h0007);
        chk("rd2_oe_dat", {31'h0, data_oe_all}, 32'h1);
        chk("rd2_oe_end", {31'h0, oe_after},    32'h0);
        chk("rd2_err",    err_cnt,              32'h0);

        rd_reg("rd0_rst", 5'd0, 16'h3100);
        rd_reg("rd1_rst", 5'd1, 16'h786D);
        rd_reg("rd3_rst", 5'd3, 16'hC0F1);

        // Write then read back a writable register.
        frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h01E1, 16);
        chk("wr4_strb", strb_cnt,              32'h1);
        chk("wr4_addr", {27'h0, last_addr},    32'h4);
        chk("wr4_data", {16'h0, last_data},    32'h01E1);
        chk("wr4_oe",   oe_cnt,                32'h0);
        rd_reg("rd4_back", 5'd4, 16'h01E1);

        // Read-only register ignores the write.
        frame(32, 2'b01, 5'd1, 5'd3, 2'b10, 16'hFFFF, 16);
        chk("wr3_strb", strb_cnt, 32'h0);
        rd_reg("rd3_ro", 5'd3, 16'hC0F1);

        // Soft reset through BMCR bit 15.
        frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'hAAAA, 16);
        chk("wr4a_strb", strb_cnt, 32'h1);
        rd_reg("rd4_aaaa", 5'd4, 16'hAAAA);
        frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h8000, 16);
        chk("wr0_strb", strb_cnt,           32'h1);
        chk("wr0_addr", {27'h0, last_addr}, 32'h0);
        chk("wr0_data", {16'h0, last_data}, 32'h8000);
        rd_reg("rd4_srst", 5'd4, 16'h0000);
        rd_reg("rd0_srst", 5'd0, 16'h3100);

        // Preamble one short: frame is not recognised.
        frame(31, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0000, 16);
        chk("pre31_oe",  oe_cnt,  32'h0);
        chk("pre31_err", err_cnt, 32'h0);

        // Illegal opcode.
        frame(32, 2'b11, 5'd1, 5'd4, 2'b10, 16'h0000, 16);
        chk("op11_err", err_cnt,  32'h1);
        chk("op11_oe",  oe_cnt,   32'h0);
        chk("op11_wr",  strb_cnt, 32'h0);

        // Write with bad turnaround.
        frame(32, 2'b01, 5'd1, 5'd4, 2'b11, 16'h5555, 16);
        chk("ta11_err",  err_cnt,  32'h1);
        chk("ta11_strb", strb_cnt, 32'h0);
        rd_reg("rd4_ta11", 5'd4, 16'h0000);

        // Other PHY address: never drives, never writes.
        frame(32, 2'b10, 5'd2, 5'd2, 2'b11, 16'h0000, 16);
        chk("pa2_rd_oe", oe_cnt, 32'h0);
        chk("pa2_rd_dat", {16'h0, rd_dat}, 32'hFFFF);
        frame(32, 2'b01, 5'd2, 5'd4, 2'b10, 16'h1234, 16);
        chk("pa2_wr_strb", strb_cnt, 32'h0);
        rd_reg("rd4_pa2", 5'd4, 16'h0000);

        // Reset in the middle of a read's data phase.
        frame(32, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0000, 8);
        chk("mid_oe_on", {31'h0, MDIO_OE},    32'h1);
        chk("mid_hi",    {24'h0, rd_dat[15:8]}, 32'h0);
        Eth_Rst = 1'b1;
        @(negedge Eth_Clk);
        chk("mid_rst_oe", {31'h0, MDIO_OE}, 32'h0);
        Eth_Rst = 1'b0;
        repeat (4) @(negedge Eth_Clk);
        rd_reg("rd2_after_rst", 5'd2, 16'h0007);
        chk("rd2_after_end", {31'h0, oe_after}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
